act_stream_tx: RTL and testbench
================================

# act_stream_tx

Activation stream transmitter for the convolution accelerator's `a` input port. On `start` it reads a contiguous block of activation words from a single-port SRAM (1-cycle read latency) and presents them on the `a_input`/`a_valid`/`a_ready` handshake, with `a_zero_flag` marking zero-valued words so the consumer can skip them. It is the producer end of the stream that the accelerator core consumes. A small prefetch FIFO hides memory latency and sustains one word per cycle.

## Interface
Parameters:
- `DATA_WIDTH`, 16, activation word width; matches `cfg.DATA_WIDTH`.
- `ADDR_WIDTH`, 12, SRAM word-address width.
- `LEN_WIDTH`, 13, width of the word-count input; the maximum length is 2^LEN_WIDTH−1.

Ports:
- `clk` in 1: the single clock; everything is on the rising edge.
- `arst` in 1: reset, asynchronous and active-high.
- `start` in 1: one-cycle pulse that launches a transfer. It is sampled only in IDLE.
- `base_addr` in ADDR_WIDTH: first word address. Sampled with `start`.
- `length` in LEN_WIDTH: number of words to send. Sampled with `start`.
- `mem_re` out 1: SRAM read enable.
- `mem_addr` out ADDR_WIDTH: SRAM read address.
- `mem_rdata` in DATA_WIDTH: SRAM read data. It is valid the cycle after `mem_re`.
- `a_input` out DATA_WIDTH: stream data (FIFO head).
- `a_valid` out 1: stream valid.
- `a_ready` in 1: consumer ready.
- `a_zero_flag` out 1: the current `a_input` equals 0. Qualified by `a_valid`.
- `busy` out 1: a transfer is in progress.
- `done` out 1: one-cycle pulse when a transfer completes.

## Operation
- The FSM has three states: IDLE, STREAM and FINISH.
- **IDLE**
  - On `start`=1, latch `base_addr` into `rd_addr`, `length` into `rd_left` and `length` into `tx_left`.
  - If `length`≠0, go to STREAM. If `length`=0, go to FINISH with no reads.
- **STREAM**
  - Read issue: `mem_re`=1 when `rd_left`≠0 and `fifo_count + inflight < 3`.
    - `mem_addr` = `rd_addr`.
    - Each issue does `rd_addr`++ and `rd_left`−−. `rd_addr` wraps modulo 2^ADDR_WIDTH.
  - `inflight` is a 1-bit register equal to the previous cycle's `mem_re`. When it is set, `mem_rdata` is pushed into the FIFO.
  - There is no combinational path from `a_ready` to `mem_re`.
- **FIFO**
  - Three entries, registered. Push and pop in the same cycle are both allowed and leave the count unchanged.
  - The credit rule guarantees no overflow.
- **Handshake**
  - `a_valid` = (`fifo_count`≠0).
  - A transfer occurs when `a_valid && a_ready`. It pops the head and does `tx_left`−−.
  - While `a_valid`=1 and `a_ready`=0, `a_input` and `a_zero_flag` hold stable.
- When `tx_left` reaches 0 on a transfer, go to FINISH.
- **FINISH**
  - `done`=1 for one cycle, then return to IDLE.
- `busy` = (state ≠ IDLE).
- `start` is ignored while `busy`=1.
- **Reset**
  - `arst` asserted at any time clears FSM→IDLE, FIFO count, `inflight`, `rd_left` and `tx_left`.
  - A mid-transfer stream is abandoned. No `done` is issued.

## Timing
- Reset values: `mem_re`=0, `mem_addr`=0, `a_valid`=0, `a_input`=0, `a_zero_flag`=0, `busy`=0, `done`=0.
- Start-to-first-word latency, with `start` sampled at edge N:
  - `mem_re`=1 in cycle N+1.
  - Data arrives in N+2 and is pushed.
  - `a_valid`=1 in cycle N+3.
- Throughput: with `a_ready` held high, one word per cycle after the first.
- Completion: `done` pulses the cycle after the edge that accepted the last word. `busy` falls together with `done`.
- Transfer with `length`=0: `done` is in cycle N+1, with no `mem_re` and no `a_valid`.
- Backpressure: reads stop once 3 words are buffered or in flight. They resume the cycle after a pop frees a slot.

## Configuration
- `ACT_STREAM_ZERO_FLAG_EN`
  - **Defined:** `a_zero_flag` = (`a_input` == 0), computed at push and stored per FIFO entry (registered, no comparator on the output path).
  - **Undefined:** `a_zero_flag` is tied to 0 and the per-entry flag bits are not built. Zero words are sent as ordinary data.

## Test plan
- **Basic stream with zero flags:** SRAM[0x10..0x13] = {5, 0, 7, 0}, `base_addr`=0x10, `length`=4, `a_ready`=1.
  - `a_input` = 5, 0, 7, 0 in cycles N+3..N+6.
  - With the macro defined, `a_zero_flag` = 0, 1, 0, 1.
  - `done` in N+7.
- **Backpressure:** same data; `a_ready`=0 in cycles N+3..N+8, then 1.
  - At most 3 `mem_re` pulses occur before the first pop.
  - `a_input`=5 is held stable through the stall.
  - All 4 words are delivered in order, then `done`.
- **Zero length:** `length`=0 → `done` in N+1, `mem_re` never asserted, `a_valid` never asserted.
- **Address wrap and start while busy:**
  - `base_addr`=0xFFE, `length`=4 → read addresses 0xFFE, 0xFFF, 0x000, 0x001.
  - A second `start` pulse in cycle N+2 is ignored: exactly 4 words are sent and there is one `done`.
- **Reset mid-stream:**
  - `length`=8. Assert `arst` after the 3rd transfer → all outputs return to reset values immediately. No `done`.
  - A new `start` with `length`=2 then delivers exactly 2 words.
- **Macro off:** run the basic stream without `ACT_STREAM_ZERO_FLAG_EN` → `a_zero_flag` is 0 for all 4 words, and the data is identical.

Source files
------------

// File: rtl/act_stream_tx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : act_stream_tx                                              |
// | Description : Activation stream transmitter. Reads a contiguous block of |
// |               activation words from a 1-cycle-latency SRAM through a     |
// |               3-entry prefetch FIFO and presents them on a valid/ready   |
// |               stream with an optional per-word zero flag.                |
// | Option      : ACT_STREAM_ZERO_FLAG_EN - build per-entry zero flags.      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module act_stream_tx #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 12,
  parameter int LEN_WIDTH  = 13
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [LEN_WIDTH-1:0]  length,
  output logic                  mem_re,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [DATA_WIDTH-1:0] a_input,
  output logic                  a_valid,
  input  logic                  a_ready,
  output logic                  a_zero_flag,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [LEN_WIDTH-1:0]  LEN_ONE  = {{(LEN_WIDTH-1){1'b0}}, 1'b1};

  state_t                state, state_next;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [LEN_WIDTH-1:0]  rd_left;
  logic [LEN_WIDTH-1:0]  tx_left;
  logic                  inflight;
  logic [DATA_WIDTH-1:0] fifo_data [3];
  logic [1:0]            wr_ptr, rd_ptr, fifo_count;
  logic                  launch, issue, push, pop;

  // Pointers walk 0,1,2,0,... over the three FIFO slots.
  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Credit check counts buffered plus in-flight words only, so a_ready never
  // reaches mem_re combinationally.
  assign launch  = (state == S_IDLE) && start;
  assign issue   = (state == S_STREAM) && (rd_left != '0) &&
                   (({1'b0, fifo_count} + {2'b00, inflight}) < 3'd3);
  assign push    = inflight;
  assign a_valid = (fifo_count != 2'd0);
  assign pop     = a_valid && a_ready;

  assign mem_re   = issue;
  assign mem_addr = rd_addr;
  assign a_input  = fifo_data[rd_ptr];
  assign busy     = (state != S_IDLE);
  assign done     = (state == S_FINISH);

  // State register.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) state <= S_IDLE;
    else      state <= state_next;
  end

  // Next-state logic: zero-length jumps straight to FINISH; last pop ends STREAM.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (start) state_next = (length != '0) ? S_STREAM : S_FINISH;
      S_STREAM: if (pop && (tx_left == LEN_ONE)) state_next = S_FINISH;
      S_FINISH: state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // Read/transmit counters and the one-deep read-latency tracker.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      rd_addr  <= '0;
      rd_left  <= '0;
      tx_left  <= '0;
      inflight <= 1'b0;
    end else begin
      inflight <= issue;
      if (launch) begin
        rd_addr <= base_addr;
        rd_left <= length;
        tx_left <= length;
      end else begin
        if (issue) begin
          rd_addr <= rd_addr + ADDR_ONE;
          rd_left <= rd_left - LEN_ONE;
        end
        if (pop) tx_left <= tx_left - LEN_ONE;
      end
    end
  end

  // Prefetch FIFO storage and occupancy; data is cleared so a_input resets to 0.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      for (int i = 0; i < 3; i++) fifo_data[i] <= '0;
      wr_ptr     <= 2'd0;
      rd_ptr     <= 2'd0;
      fifo_count <= 2'd0;
    end else begin
      if (push) begin
        fifo_data[wr_ptr] <= mem_rdata;
        wr_ptr            <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 2'd1;
        2'b01:   fifo_count <= fifo_count - 2'd1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

`ifdef ACT_STREAM_ZERO_FLAG_EN
  logic [2:0] fifo_zero;

  // Zero detection happens at push time so the output is a plain register.
  always_ff @(posedge clk or posedge arst) begin
    if (arst)      fifo_zero <= 3'b000;
    else if (push) fifo_zero[wr_ptr] <= (mem_rdata == '0);
  end

  assign a_zero_flag = fifo_zero[rd_ptr];
`else
  assign a_zero_flag = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_act_stream_tx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_act_stream_tx                                           |
// | Description : Self-checking bench for act_stream_tx (table-driven cycle  |
// |               vectors plus hand-written multi-cycle sequences).          |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_act_stream_tx;

`ifdef ACT_STREAM_ZERO_FLAG_EN
  localparam bit ZF_EN = 1'b1;
`else
  localparam bit ZF_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        arst;
  logic        start;
  logic [11:0] base_addr;
  logic [12:0] length;
  logic        mem_re;
  logic [11:0] mem_addr;
  logic [15:0] mem_rdata = '0;
  logic [15:0] a_input;
  logic        a_valid;
  logic        a_ready;
  logic        a_zero_flag;
  logic        busy;
  logic        done;

  act_stream_tx #(.DATA_WIDTH(16), .ADDR_WIDTH(12), .LEN_WIDTH(13)) dut (
    .clk(clk), .arst(arst), .start(start), .base_addr(base_addr),
    .length(length), .mem_re(mem_re), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .a_input(a_input), .a_valid(a_valid),
    .a_ready(a_ready), .a_zero_flag(a_zero_flag), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // SRAM model with one-cycle read latency.
  logic [15:0] sram [0:4095];
  always @(posedge clk) if (mem_re) mem_rdata <= sram[mem_addr];

  // Event logs captured at the active edge.
  logic [11:0] rd_log [$];
  logic [15:0] rx [$];
  int          re_cnt = 0;
  int          done_cnt = 0;
  always @(posedge clk) begin
    if (mem_re) begin
      rd_log.push_back(mem_addr);
      re_cnt = re_cnt + 1;
    end
    if (a_valid && a_ready) rx.push_back(a_input);
    if (done) done_cnt = done_cnt + 1;
  end

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rdy;
    logic        re;
    logic        vld;
    logic [15:0] dat;
    logic        zf;
    logic        dn;
    logic        bsy;
  } vec_t;

  vec_t tbl [$];

  task automatic add(input logic rdy, input logic re, input logic vld,
                     input logic [15:0] dat, input logic zf, input logic dn,
                     input logic bsy);
    vec_t v;
    v.rdy = rdy; v.re = re; v.vld = vld; v.dat = dat;
    v.zf = zf; v.dn = dn; v.bsy = bsy;
    tbl.push_back(v);
  endtask

  // Drive a start pulse sampled at edge N; returns #1 into cycle N+1.
  task automatic do_start(input logic [11:0] base, input logic [12:0] len);
    @(negedge clk);
    start = 1'b1; base_addr = base; length = len;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Apply table row k in cycle N+k, compare at the falling edge.
  task automatic run_table(input string tag);
    for (int k = 0; k < tbl.size(); k++) begin
      a_ready = tbl[k].rdy;
      @(negedge clk);
      check($sformatf("%s c%0d mem_re", tag, k + 1), {31'b0, mem_re}, {31'b0, tbl[k].re});
      check($sformatf("%s c%0d a_valid", tag, k + 1), {31'b0, a_valid}, {31'b0, tbl[k].vld});
      check($sformatf("%s c%0d done", tag, k + 1), {31'b0, done}, {31'b0, tbl[k].dn});
      check($sformatf("%s c%0d busy", tag, k + 1), {31'b0, busy}, {31'b0, tbl[k].bsy});
      if (tbl[k].vld) begin
        check($sformatf("%s c%0d a_input", tag, k + 1), {16'b0, a_input}, {16'b0, tbl[k].dat});
        check($sformatf("%s c%0d zero_flag", tag, k + 1), {31'b0, a_zero_flag},
              {31'b0, tbl[k].zf & ZF_EN});
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " mem_re"}, {31'b0, mem_re}, 32'd0);
    check({tag, " mem_addr"}, {20'b0, mem_addr}, 32'd0);
    check({tag, " a_valid"}, {31'b0, a_valid}, 32'd0);
    check({tag, " a_input"}, {16'b0, a_input}, 32'd0);
    check({tag, " zero_flag"}, {31'b0, a_zero_flag}, 32'd0);
    check({tag, " busy"}, {31'b0, busy}, 32'd0);
    check({tag, " done"}, {31'b0, done}, 32'd0);
  endtask

  initial begin
    int waited;
    for (int i = 0; i < 4096; i++) sram[i] = 16'hA5A5;
    sram[12'h010] = 16'd5; sram[12'h011] = 16'd0;
    sram[12'h012] = 16'd7; sram[12'h013] = 16'd0;
    sram[12'hFFE] = 16'd11; sram[12'hFFF] = 16'd0;
    sram[12'h000] = 16'd13; sram[12'h001] = 16'd14;
    for (int i = 0; i < 8; i++) sram[12'h020 + i] = 16'(i + 1);

    arst = 1'b1; start = 1'b0; base_addr = '0; length = '0; a_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    arst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Basic stream, consumer always ready.
    tbl.delete();
    add(1, 1, 0, 0, 0, 0, 1);
    add(1, 1, 0, 0, 0, 0, 1);
    add(1, 1, 1, 5, 0, 0, 1);
    add(1, 1, 1, 0, 1, 0, 1);
    add(1, 0, 1, 7, 0, 0, 1);
    add(1, 0, 1, 0, 1, 0, 1);
    add(1, 0, 0, 0, 0, 1, 1);
    add(1, 0, 0, 0, 0, 0, 0);
    do_start(12'h010, 13'd4);
    run_table("basic");

    // Backpressure: stall in N+3..N+8, credits cap reads at three.
    tbl.delete();
    add(0, 1, 0, 0, 0, 0, 1);
    add(0, 1, 0, 0, 0, 0, 1);
    add(0, 1, 1, 5, 0, 0, 1);
    for (int k = 4; k <= 8; k++) add(0, 0, 1, 5, 0, 0, 1);
    add(1, 0, 1, 5, 0, 0, 1);
    add(1, 1, 1, 0, 1, 0, 1);
    add(1, 0, 1, 7, 0, 0, 1);
    add(1, 0, 1, 0, 1, 0, 1);
    add(1, 0, 0, 0, 0, 1, 1);
    add(1, 0, 0, 0, 0, 0, 0);
    do_start(12'h010, 13'd4);
    run_table("bp");

    // Zero length: done in N+1, no reads, no valid.
    re_cnt = 0;
    tbl.delete();
    add(1, 0, 0, 0, 0, 1, 1);
    add(1, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0);
    do_start(12'h010, 13'd0);
    run_table("zero");
    check("zero re_count", re_cnt, 0);

    // Address wrap with a second start in N+2 that must be ignored.
    rd_log.delete(); rx.delete(); done_cnt = 0;
    a_ready = 1'b1;
    do_start(12'hFFE, 13'd4);
    @(posedge clk);
    #1 start = 1'b1; base_addr = 12'h010; length = 13'd4;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("wrap read_count", rd_log.size(), 4);
    if (rd_log.size() == 4) begin
      check("wrap addr0", {20'b0, rd_log[0]}, 32'hFFE);
      check("wrap addr1", {20'b0, rd_log[1]}, 32'hFFF);
      check("wrap addr2", {20'b0, rd_log[2]}, 32'h000);
      check("wrap addr3", {20'b0, rd_log[3]}, 32'h001);
    end
    check("wrap word_count", rx.size(), 4);
    if (rx.size() == 4) begin
      check("wrap word0", {16'b0, rx[0]}, 32'd11);
      check("wrap word1", {16'b0, rx[1]}, 32'd0);
      check("wrap word2", {16'b0, rx[2]}, 32'd13);
      check("wrap word3", {16'b0, rx[3]}, 32'd14);
    end
    check("wrap done_count", done_cnt, 1);

    // Reset mid-stream after the third transfer.
    rx.delete(); done_cnt = 0;
    a_ready = 1'b1;
    do_start(12'h020, 13'd8);
    waited = 0;
    while (rx.size() < 3 && waited < 30) begin
      @(posedge clk);
      #1;
      waited++;
    end
    check("rst third_transfer_seen", {31'b0, (rx.size() >= 3)}, 32'd1);
    #1 arst = 1'b1;
    #1;
    check_reset_outputs("rst mid");
    @(posedge clk);
    #1 arst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("rst no_done", done_cnt, 0);
    rx.delete();
    do_start(12'h020, 13'd2);
    repeat (15) @(posedge clk);
    #1;
    check("restart word_count", rx.size(), 2);
    if (rx.size() == 2) begin
      check("restart word0", {16'b0, rx[0]}, 32'd1);
      check("restart word1", {16'b0, rx[1]}, 32'd2);
    end
    check("restart done_count", done_cnt, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
